// File: rtl/storage_transfer_controller.sv
// Storage-to-main-memory block copy engine that owns the storage port while busy.
// Optional XOR checksum of copied words: define STORAGE_TRANSFER_CHECKSUM_EN.
module storage_transfer_controller #(
  parameter int DW             = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int COUNT_WIDTH    = 14
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src_address,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_address,
  input  logic [COUNT_WIDTH-1:0]    word_count,
  output logic                      busy,
  output logic                      done,
  input  logic [ADDR_WIDTH-1:0]     cpu_storage_address,
  input  logic [DW-1:0]             cpu_storage_data,
  input  logic                      cpu_storage_write_enable,
  output logic                      cpu_storage_granted,
  output logic [ADDR_WIDTH-1:0]     storage_address,
  output logic [DW-1:0]             storage_input_data,
  output logic                      storage_write_enable,
  input  logic [DW-1:0]             storage_output_data,
`ifdef STORAGE_TRANSFER_CHECKSUM_EN
  output logic [DW-1:0]             checksum,
`endif
  output logic [MEM_ADDR_WIDTH-1:0] memory_address,
  output logic [DW-1:0]             memory_data,
  output logic                      memory_write_enable
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [COUNT_WIDTH-1:0]    CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]     SRC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MEM_ADDR_WIDTH-1:0] DST_ONE = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     src_ptr;
  logic [MEM_ADDR_WIDTH-1:0] dst_ptr;
  logic [COUNT_WIDTH-1:0]    cnt;
  logic                      accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (accept && word_count != '0) begin
        src_ptr <= src_address;
        dst_ptr <= dst_address;
        cnt     <= word_count;
      end else if (state == WRITE) begin
        // pointers wrap silently at their natural widths
        src_ptr <= src_ptr + SRC_ONE;
        dst_ptr <= dst_ptr + DST_ONE;
        cnt     <= cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (word_count == '0) ? DONE : READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = (cnt == CNT_ONE) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy                = (state == READ) || (state == WRITE);
  assign done                = (state == DONE);
  assign memory_write_enable = (state == WRITE);
  // read data registered by the drive lands during WRITE, so it goes straight out
  assign memory_address      = memory_write_enable ? dst_ptr : '0;
  assign memory_data         = memory_write_enable ? storage_output_data : '0;

  assign cpu_storage_granted  = !busy;
  assign storage_address      = busy ? src_ptr : cpu_storage_address;
  assign storage_input_data   = busy ? '0 : cpu_storage_data;
  assign storage_write_enable = busy ? 1'b0 : cpu_storage_write_enable;

`ifdef STORAGE_TRANSFER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    checksum <= '0;
    else if (accept)               checksum <= '0;
    else if (memory_write_enable)  checksum <= checksum ^ storage_output_data;
  end
`endif

endmodule

// File: tb/tb_storage_transfer_controller.sv
// Self-checking bench: transaction-level model plus directed copy scenarios.
module tb_storage_transfer_controller;
  localparam int DW = 32, AW = 14, MW = 16, CW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_address = '0;
  logic [MW-1:0] dst_address = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, cpu_storage_granted;
  logic [AW-1:0] cpu_storage_address = '0;
  logic [DW-1:0] cpu_storage_data = '0;
  logic          cpu_storage_write_enable = 1'b0;
  logic [AW-1:0] storage_address;
  logic [DW-1:0] storage_input_data;
  logic          storage_write_enable;
  logic [DW-1:0] storage_output_data = '0;
  logic [MW-1:0] memory_address;
  logic [DW-1:0] memory_data;
  logic          memory_write_enable;
  logic [DW-1:0] checksum;

  storage_transfer_controller #(.DW(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_address(src_address), .dst_address(dst_address), .word_count(word_count),
    .busy(busy), .done(done),
    .cpu_storage_address(cpu_storage_address), .cpu_storage_data(cpu_storage_data),
    .cpu_storage_write_enable(cpu_storage_write_enable), .cpu_storage_granted(cpu_storage_granted),
    .storage_address(storage_address), .storage_input_data(storage_input_data),
    .storage_write_enable(storage_write_enable), .storage_output_data(storage_output_data),
`ifdef STORAGE_TRANSFER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .memory_address(memory_address), .memory_data(memory_data),
    .memory_write_enable(memory_write_enable)
  );

`ifndef STORAGE_TRANSFER_CHECKSUM_EN
  assign checksum = '0;
`endif

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // storage drive: sparse overrides on top of a fixed initial image
  logic [DW-1:0] smem [int];
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    case (a)
      14'd5:      return 32'hA;
      14'd6:      return 32'hB;
      14'd7:      return 32'hC;
      14'd8:      return 32'hD;
      14'h3FFF:   return 32'hDEAD_0001;
      14'h0000:   return 32'hDEAD_0002;
      default:    return 32'h5A00_0000 | {18'd0, a};
    endcase
  endfunction
  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return smem.exists(int'(a)) ? smem[int'(a)] : init_word(a);
  endfunction

  always @(posedge clock) begin
    storage_output_data <= rd(storage_address);
    if (storage_write_enable) smem[int'(storage_address)] = storage_input_data;
  end

  // main memory and event counters
  logic [DW-1:0] mmem [int];
  int wr_count = 0, done_count = 0, busy_count = 0;
  always @(posedge clock) begin
    if (memory_write_enable) begin
      mmem[int'(memory_address)] = memory_data;
      wr_count++;
    end
    if (done) done_count++;
    if (busy) busy_count++;
  end
  function automatic logic [DW-1:0] mm(input int a);
    return mmem.exists(a) ? mmem[a] : 32'hFFFF_FFFF;
  endfunction

  // model: an accepted start at the end of cycle S with N words gives
  // busy in cycles S+1..S+2N, a write every even offset, done at S+2N+1
  int cyc = 0, m_s = 0, m_n = 0;
  bit m_active = 0;
  logic [AW-1:0] m_src = '0;
  logic [MW-1:0] m_dst = '0;
  always @(posedge clock) begin
    if (!reset) m_active = 0;
    else if (start && !(m_active && cyc >= m_s + 1 && cyc <= m_s + 2 * m_n + 1)) begin
      m_active = 1; m_s = cyc; m_n = int'(word_count);
      m_src = src_address; m_dst = dst_address;
    end
    cyc++;
  end

  logic [DW-1:0] mck = '0;
  always @(negedge clock) begin
    int k;
    bit inx, eb, ed, ew;
    logic [AW-1:0] esa, rsa;
    logic [MW-1:0] ema;
    logic [DW-1:0] emd;
    k = cyc - m_s;
    inx = reset && m_active && k >= 1 && k <= 2 * m_n + 1;
    eb = inx && k <= 2 * m_n;
    ed = inx && k == 2 * m_n + 1;
    ew = eb && (k % 2 == 0);
    if (!reset || (inx && k == 1)) mck = '0;
    esa = eb ? AW'(int'(m_src) + (k - 1) / 2) : cpu_storage_address;
    rsa = AW'(int'(m_src) + k / 2 - 1);
    ema = ew ? MW'(int'(m_dst) + k / 2 - 1) : '0;
    emd = ew ? rd(rsa) : '0;
    check("busy", busy, eb);
    check("done", done, ed);
    check("granted", cpu_storage_granted, !eb);
    check("st_addr", storage_address, esa);
    check("st_we", storage_write_enable, eb ? 1'b0 : cpu_storage_write_enable);
    check("st_din", storage_input_data, eb ? '0 : cpu_storage_data);
    check("mem_we", memory_write_enable, ew);
    check("mem_addr", memory_address, ema);
    check("mem_data", memory_data, emd);
`ifdef STORAGE_TRANSFER_CHECKSUM_EN
    check("checksum", checksum, mck);
`endif
    if (ew) mck = mck ^ emd;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic issue(input logic [AW-1:0] s, input logic [MW-1:0] d, input logic [CW-1:0] n);
    src_address = s; dst_address = d; word_count = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // lat = cycles from the start cycle to the done cycle
  task automatic wait_done(output int lat);
    lat = 1;
    forever begin
      @(negedge clock);
      if (done) break;
      if (lat >= 200) begin check("done_timeout", done, 1'b1); break; end
      @(posedge clock); #1;
      lat++;
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int lat, d0, w0, b0;
    // reset state
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mwe", memory_write_enable, 1'b0);
    check("rst_granted", cpu_storage_granted, 1'b1);
    reset = 1'b1;
    tick();

    // basic 4-word copy
    w0 = wr_count; d0 = done_count;
    issue(14'd5, 16'h100, 14'd4);
    wait_done(lat);
    check("lat4", lat, 9);
    check("wr4", wr_count - w0, 4);
    check("done4", done_count - d0, 1);
    check("m100", mm(32'h100), 32'hA);
    check("m101", mm(32'h101), 32'hB);
    check("m102", mm(32'h102), 32'hC);
    check("m103", mm(32'h103), 32'hD);
`ifdef STORAGE_TRANSFER_CHECKSUM_EN
    check("ck4", checksum, 32'h0);
`endif
    tick();

    // zero-length request
    w0 = wr_count; b0 = busy_count;
    issue(14'd5, 16'h180, 14'd0);
    wait_done(lat);
    check("lat0", lat, 1);
    check("wr0", wr_count - w0, 0);
    check("busy0", busy_count - b0, 0);

    // source pointer wrap
    issue(14'h3FFF, 16'h600, 14'd2);
    wait_done(lat);
    check("lat2", lat, 5);
    check("m600", mm(32'h600), 32'hDEAD_0001);
    check("m601", mm(32'h601), 32'hDEAD_0002);
`ifdef STORAGE_TRANSFER_CHECKSUM_EN
    check("ck2", checksum, 32'h3);
`endif

    // CPU write dropped while busy, forwarded while idle
    issue(14'h10, 16'h200, 14'd3);
    tick();
    cpu_storage_address = 14'h10; cpu_storage_data = 32'hBAD; cpu_storage_write_enable = 1'b1;
    @(negedge clock);
    check("drop_we", storage_write_enable, 1'b0);
    check("drop_gnt", cpu_storage_granted, 1'b0);
    repeat (3) tick();
    cpu_storage_write_enable = 1'b0;
    wait_done(lat);
    check("drop_mem", rd(14'h10), 32'h5A00_0010);
    check("m202", mm(32'h202), 32'h5A00_0012);
    cpu_storage_address = 14'h20; cpu_storage_data = 32'h55; cpu_storage_write_enable = 1'b1;
    @(negedge clock);
    check("fwd_gnt", cpu_storage_granted, 1'b1);
    tick();
    cpu_storage_write_enable = 1'b0;
    check("fwd_mem", rd(14'h20), 32'h55);

    // reset during the third word aborts the copy
    d0 = done_count;
    issue(14'd5, 16'h300, 14'd4);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_mwe", memory_write_enable, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("abort_nodone", done_count - d0, 0);
    check("m300", mm(32'h300), 32'hA);
    check("m301", mm(32'h301), 32'hB);
    check("m302", mm(32'h302), 32'hFFFF_FFFF);
    issue(14'd7, 16'h310, 14'd2);
    wait_done(lat);
    check("lat_after", lat, 5);
    check("m310", mm(32'h310), 32'hC);
    check("m311", mm(32'h311), 32'hD);

    // second start during a transfer is ignored
    d0 = done_count; w0 = wr_count;
    issue(14'd5, 16'h400, 14'd2);
    tick();
    issue(14'h3FFF, 16'h500, 14'd3);
    repeat (12) tick();
    check("ign_done", done_count - d0, 1);
    check("ign_wr", wr_count - w0, 2);
    check("m401", mm(32'h401), 32'hB);
    check("m500", mm(32'h500), 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
